// File: rtl/wb_writeback.sv
// rtl/wb_writeback.sv - LEGv8 writeback stage: latches MEM/WB results, drives the register-file write port
// and stalls the memory stage while load data is outstanding.
module wb_writeback #(
  parameter int WORD     = 64,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic [4:0]          Rd_num_in,
  input  logic [WORD-1:0]     ALU_result,
  input  logic                MemtoReg,
  input  logic                RegWrite_in,
  input  logic                mem_rd_valid,
  input  logic [WORD-1:0]     mem_rd_data,
  output logic [WORD-1:0]     Write_data,
  output logic [4:0]          Write_register,
  output logic                RegWrite,
  output logic                wb_busy,
  output logic [RETIRE_W-1:0] retired_count
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_MEM} state_t;

  state_t     state;
  state_t     next_state;
  logic [4:0] pending_rd;
  logic       writes_reg;
  logic       alu_write;
  logic       load_start;
  logic       mem_write;

  // XZR (register 31) is a discard target, so it never produces a write.
  assign writes_reg = RegWrite_in && (Rd_num_in != 5'd31);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, WRITE: begin
        if (valid_in && writes_reg) begin
          next_state = MemtoReg ? WAIT_MEM : WRITE;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rd_valid) begin
          next_state = WRITE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_out  = (state != WAIT_MEM);
    wb_busy    = (state == WAIT_MEM);
    alu_write  = 1'b0;
    load_start = 1'b0;
    mem_write  = 1'b0;
    if (state == WAIT_MEM) begin
      mem_write = mem_rd_valid;
    end else if (valid_in && writes_reg) begin
      alu_write  = !MemtoReg;
      load_start = MemtoReg;
    end
  end

  // Write port and retire counter; data/address hold whenever no write happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Write_data     <= '0;
      Write_register <= '0;
      RegWrite       <= 1'b0;
      retired_count  <= '0;
      pending_rd     <= '0;
    end else begin
      RegWrite <= alu_write || mem_write;
      if (alu_write) begin
        Write_data     <= ALU_result;
        Write_register <= Rd_num_in;
      end else if (mem_write) begin
        Write_data     <= mem_rd_data;
        Write_register <= pending_rd;
      end
      if (load_start) begin
        pending_rd <= Rd_num_in;
      end
      if (alu_write || mem_write) begin
        retired_count <= retired_count + RETIRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_writeback.sv
// tb/tb_wb_writeback.sv - self-checking bench for wb_writeback: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_wb_writeback;

  localparam int WORD = 64;
  localparam int RW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_in;
  logic            ready_out;
  logic [4:0]      Rd_num_in;
  logic [WORD-1:0] ALU_result;
  logic            MemtoReg;
  logic            RegWrite_in;
  logic            mem_rd_valid;
  logic [WORD-1:0] mem_rd_data;
  logic [WORD-1:0] Write_data;
  logic [4:0]      Write_register;
  logic            RegWrite;
  logic            wb_busy;
  logic [RW-1:0]   retired_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  wb_writeback #(.WORD(WORD), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .Rd_num_in(Rd_num_in), .ALU_result(ALU_result), .MemtoReg(MemtoReg),
    .RegWrite_in(RegWrite_in), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .Write_data(Write_data), .Write_register(Write_register), .RegWrite(RegWrite),
    .wb_busy(wb_busy), .retired_count(retired_count)
  );

  task automatic drive_idle();
    valid_in = 1'b0; Rd_num_in = '0; ALU_result = '0; MemtoReg = 1'b0;
    RegWrite_in = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [WORD-1:0] val);
    valid_in = 1'b1; Rd_num_in = rd; ALU_result = val; MemtoReg = 1'b0; RegWrite_in = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    n_checks++; if (RegWrite !== 1'b0) $display("FAIL reset_hold_regwrite: got %0b want 0", RegWrite); else n_pass++;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    exp_count = 0;
    n_checks++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite: got %0b want 0", RegWrite); else n_pass++;
    n_checks++; if (retired_count !== 0) $display("FAIL reset_count: got %0d want 0", retired_count); else n_pass++;
    n_checks++; if (ready_out !== 1'b1) $display("FAIL reset_ready: got %0b want 1", ready_out); else n_pass++;
    n_checks++; if (Write_data !== 64'd0) $display("FAIL reset_wdata: got %h want 0", Write_data); else n_pass++;
    n_checks++; if (Write_register !== 5'd0) $display("FAIL reset_wreg: got %0d want 0", Write_register); else n_pass++;
    n_checks++; if (wb_busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", wb_busy); else n_pass++;
  endtask

  task automatic test_alu_writeback();
    drive_alu(5'd5, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    drive_idle();
    exp_count = (exp_count + 1) % (1 << RW);
    n_checks++; if (RegWrite !== 1'b1) $display("FAIL alu_regwrite: got %0b want 1", RegWrite); else n_pass++;
    n_checks++; if (Write_register !== 5'd5) $display("FAIL alu_wreg: got %0d want 5", Write_register); else n_pass++;
    n_checks++; if (Write_data !== 64'hDEAD_BEEF) $display("FAIL alu_wdata: got %h want deadbeef", Write_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (RegWrite !== 1'b0) $display("FAIL alu_pulse_end: got %0b want 0", RegWrite); else n_pass++;
    n_checks++; if (retired_count !== 1) $display("FAIL alu_count: got %0d want 1", retired_count); else n_pass++;
    n_checks++; if (Write_data !== 64'hDEAD_BEEF) $display("FAIL alu_wdata_hold: got %h want deadbeef", Write_data); else n_pass++;
  endtask

  task automatic test_load_stall();
    valid_in = 1'b1; Rd_num_in = 5'd9; ALU_result = 64'h40; MemtoReg = 1'b1; RegWrite_in = 1'b1;
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ready_out !== 1'b0) $display("FAIL load_ready_%0d: got %0b want 0", i, ready_out); else n_pass++;
      n_checks++; if (wb_busy !== 1'b1) $display("FAIL load_busy_%0d: got %0b want 1", i, wb_busy); else n_pass++;
      n_checks++; if (RegWrite !== 1'b0) $display("FAIL load_regwrite_%0d: got %0b want 0", i, RegWrite); else n_pass++;
      @(negedge clk);
    end
    mem_rd_valid = 1'b1; mem_rd_data = 64'h1234;
    @(negedge clk);
    drive_idle();
    exp_count = (exp_count + 1) % (1 << RW);
    n_checks++; if (RegWrite !== 1'b1) $display("FAIL load_regwrite: got %0b want 1", RegWrite); else n_pass++;
    n_checks++; if (Write_register !== 5'd9) $display("FAIL load_wreg: got %0d want 9", Write_register); else n_pass++;
    n_checks++; if (Write_data !== 64'h1234) $display("FAIL load_wdata: got %h want 1234", Write_data); else n_pass++;
    n_checks++; if (ready_out !== 1'b1) $display("FAIL load_ready_after: got %0b want 1", ready_out); else n_pass++;
    n_checks++; if (retired_count !== exp_count) $display("FAIL load_count: got %0d want %0d", retired_count, exp_count); else n_pass++;
  endtask

  task automatic test_xzr_back_to_back();
    int start_count;
    start_count = exp_count;
    drive_alu(5'd1, 64'h11);
    @(negedge clk);
    n_checks++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd1, 64'h11})
      $display("FAIL b2b_first: got %0b/%0d/%h want 1/1/11", RegWrite, Write_register, Write_data); else n_pass++;
    drive_alu(5'd31, 64'h22);
    @(negedge clk);
    n_checks++; if ({RegWrite, Write_register, Write_data} !== {1'b0, 5'd1, 64'h11})
      $display("FAIL b2b_xzr: got %0b/%0d/%h want 0/1/11", RegWrite, Write_register, Write_data); else n_pass++;
    drive_alu(5'd2, 64'h33);
    @(negedge clk);
    drive_idle();
    n_checks++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd2, 64'h33})
      $display("FAIL b2b_third: got %0b/%0d/%h want 1/2/33", RegWrite, Write_register, Write_data); else n_pass++;
    exp_count = (start_count + 2) % (1 << RW);
    n_checks++; if (retired_count !== exp_count) $display("FAIL b2b_count: got %0d want %0d", retired_count, exp_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_wait_mem();
    valid_in = 1'b1; Rd_num_in = 5'd7; MemtoReg = 1'b1; RegWrite_in = 1'b1;
    @(negedge clk);
    drive_idle();
    n_checks++; if (wb_busy !== 1'b1) $display("FAIL rwm_busy: got %0b want 1", wb_busy); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
    mem_rd_valid = 1'b1; mem_rd_data = 64'hFF;
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (RegWrite !== 1'b0) $display("FAIL rwm_regwrite_%0d: got %0b want 0", i, RegWrite); else n_pass++;
      n_checks++; if ({ready_out, wb_busy} !== 2'b10) $display("FAIL rwm_idle_%0d: got %b want 10", i, {ready_out, wb_busy}); else n_pass++;
      n_checks++; if (retired_count !== 0) $display("FAIL rwm_count_%0d: got %0d want 0", i, retired_count); else n_pass++;
      n_checks++; if (Write_data !== 64'd0) $display("FAIL rwm_wdata_%0d: got %h want 0", i, Write_data); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_counter_wrap();
    for (int i = 1; i <= 17; i++) begin
      drive_alu(5'd3, 64'(i));
      @(negedge clk);
      exp_count = (exp_count + 1) % (1 << RW);
      n_checks++; if (RegWrite !== 1'b1) $display("FAIL wrap_pulse_%0d: got %0b want 1", i, RegWrite); else n_pass++;
      n_checks++; if (retired_count !== exp_count) $display("FAIL wrap_count_%0d: got %0d want %0d", i, retired_count, exp_count); else n_pass++;
    end
    drive_idle();
    @(negedge clk);
    n_checks++; if (retired_count !== 1) $display("FAIL wrap_final: got %0d want 1", retired_count); else n_pass++;
  endtask

  // Reference model tracks only "is a load outstanding, for which register" and which writes must appear.
  task automatic test_random();
    bit              pending = 1'b0;
    logic [4:0]      pending_rd = '0;
    logic            exp_rw = 1'b0;
    logic [4:0]      exp_wr = '0;
    logic [WORD-1:0] exp_wd = '0;
    logic [75:0]     got, want;
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!(valid_in && pending)) begin
        valid_in    = ($urandom_range(0, 2) != 0);
        Rd_num_in   = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        ALU_result  = {$urandom, $urandom};
        MemtoReg    = $urandom_range(0, 1) != 0;
        RegWrite_in = $urandom_range(0, 3) != 0;
      end
      mem_rd_valid = ($urandom_range(0, 2) == 0);
      mem_rd_data  = {$urandom, $urandom};
      exp_rw = 1'b0;
      if (pending) begin
        if (mem_rd_valid) begin
          exp_rw = 1'b1; exp_wr = pending_rd; exp_wd = mem_rd_data; pending = 1'b0;
        end
      end else if (valid_in && RegWrite_in && Rd_num_in != 5'd31) begin
        if (MemtoReg) begin
          pending = 1'b1; pending_rd = Rd_num_in;
        end else begin
          exp_rw = 1'b1; exp_wr = Rd_num_in; exp_wd = ALU_result;
        end
      end
      if (exp_rw) exp_count = (exp_count + 1) % (1 << RW);
      @(negedge clk);
      got  = {RegWrite, Write_register, Write_data, ready_out, wb_busy, retired_count};
      want = {exp_rw, exp_wr, exp_wd, !pending, pending, RW'(exp_count)};
      n_checks++;
      if (got !== want) $display("FAIL random_cycle_%0d: got %h want %h", cyc, got, want);
      else n_pass++;
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    test_reset();
    test_alu_writeback();
    test_load_stall();
    test_xzr_back_to_back();
    test_reset_wait_mem();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
